// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding request to imem, holds the returned word for decode.
// Optional FETCH_TIMEOUT_EN builds a response watchdog that sets a sticky o_err and re-fetches.
module instruction_fetch #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_valid,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_inst,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              timeout;

  wire waiting = (state_q == WAIT) || (state_q == DRAIN);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter saturates so repeated redirects in DRAIN cannot wrap it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)
      cnt_d = '0;
    else if (waiting && (cnt_q != CNT_W'(TIMEOUT)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Fires on the TIMEOUT-th wait cycle after the request without a response.
  assign timeout = waiting && !i_imem_valid && (cnt_q >= CNT_W'(TIMEOUT - 1));
  assign err_d   = err_q | (timeout & ~i_redirect);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE:  state_d = ISSUE;
      ISSUE: state_d = i_redirect ? DRAIN : WAIT;
      WAIT: begin
        if (i_imem_valid) begin
          if (i_redirect) begin
            state_d = ISSUE;
          end else begin
            inst_d    = i_imem_inst;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (i_redirect) begin
          state_d = DRAIN;
        end else if (timeout) begin
          state_d = ISSUE;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          state_d = ISSUE;
        end else if (i_inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (i_imem_valid || (timeout && !i_redirect))
          state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
    // Redirect target wins over the sequential increment, including a same-cycle handshake.
    if (i_redirect)
      pc_d = i_redirect_pc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign o_imem_valid = (state_q == ISSUE);
  assign o_imem_addr  = pc_q;
  assign o_inst_valid = (state_q == HOLD);
  assign o_inst       = inst_q;
  assign o_pc         = inst_pc_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly upstream of the instruction memory. It owns the program counter and issues one-word fetch requests to the memory. It captures the returned instruction and holds it for the decode stage under a valid/ready handshake. It also applies branch redirects from execute, discarding any response already in flight. Only one request is outstanding at a time; the memory returns data a fixed 3 cycles after a request.

## Interface
- ADDR_W, 64, PC and memory byte-address width
- INST_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- TIMEOUT, 15, maximum cycles to wait for a response (used only with FETCH_TIMEOUT_EN)

- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- o_imem_valid  output  1  fetch request strobe to memory, one-cycle pulse
- o_imem_addr  output  ADDR_W  byte address of request, equals PC
- i_imem_valid  input  1  memory response valid
- i_imem_inst  input  INST_W  memory response data
- o_inst_valid  output  1  instruction available to decode
- o_inst  output  INST_W  held instruction
- o_pc  output  ADDR_W  PC of held instruction
- i_inst_ready  input  1  decode accepts instruction this cycle
- i_redirect  input  1  redirect request from execute
- i_redirect_pc  input  ADDR_W  redirect target, word aligned
- o_err  output  1  sticky fetch-timeout flag

## Operation
- All outputs registered or decoded from registered state.
- Reset values:
  - o_imem_valid=0, o_imem_addr=RESET_PC
  - o_inst_valid=0, o_inst=0, o_pc=RESET_PC
  - o_err=0, state=IDLE, pc=RESET_PC
- State machine:
  - IDLE: go to ISSUE next cycle.
  - ISSUE: o_imem_valid=1, o_imem_addr=pc, exactly one cycle; then WAIT.
  - WAIT: on i_imem_valid, capture i_imem_inst into o_inst and pc into o_pc; go HOLD.
  - HOLD: o_inst_valid=1, o_inst/o_pc stable. On i_inst_ready: pc <= pc+4 (mod 2^ADDR_W, wraps), go ISSUE.
  - DRAIN: wait for the stale response, discard it, then go ISSUE.
- Redirect (i_redirect=1) has priority over all other events:
  - pc <= i_redirect_pc, and o_inst_valid is 0 from the next cycle.
  - In ISSUE or WAIT without a same-cycle response: go DRAIN.
  - In WAIT with a same-cycle i_imem_valid: discard the response, go ISSUE.
  - In HOLD, IDLE or DRAIN-with-response: go ISSUE.
  - In DRAIN without a response: stay DRAIN.
  - HOLD with i_inst_ready and i_redirect together: the handshake completes (decode keeps the instruction), and pc takes i_redirect_pc, not pc+4.
- i_imem_valid outside WAIT/DRAIN is ignored.
- Asynchronous reset mid-operation returns every register to its reset value immediately. Any response arriving after reset release while in IDLE is ignored.

## Timing
- Request issued in cycle t; response at t+3; o_inst_valid high at t+4.
- Ready in t+4 puts the next request in t+5. Peak throughput is 1 instruction per 5 cycles.
- First request occurs in the 2nd cycle after reset release (IDLE, then ISSUE).
- Redirect in cycle r during WAIT:
  - DRAIN absorbs the outstanding response.
  - The next ISSUE occurs the cycle after that response.
  - The new address is i_redirect_pc.
- o_inst and o_pc change only on capture; they are not required to hold their value once o_inst_valid is 0.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs in WAIT and DRAIN, cleared on every ISSUE.
  - If the counter reaches TIMEOUT without i_imem_valid, o_err is set to 1 and stays set until reset. The state goes to ISSUE with pc unchanged (re-fetch).
  - Counter width is clog2(TIMEOUT+1).
- FETCH_TIMEOUT_EN undefined:
  - No counter is built.
  - o_err is tied to 0.
  - WAIT and DRAIN wait indefinitely.

## Test plan
- Reset release, 3-cycle memory model, ready held high:
  - Requests at addresses 0x0, 0x4, 0x8 spaced 5 cycles apart.
  - o_pc/o_inst match memory words 0, 1, 2.
- Ready held low for 10 cycles in HOLD:
  - o_inst_valid stays 1; o_inst/o_pc stable; no new o_imem_valid.
  - On ready, next request to pc+4.
- Redirect to 0x100 one cycle after a request to 0x8:
  - The response for 0x8 is never presented.
  - The next request goes to 0x100, issued the cycle after the stale response.
- Redirect coincident with i_imem_valid in WAIT, and redirect plus ready together in HOLD:
  - The response is dropped, and the next request goes to the redirect target.
  - In the HOLD case, the instruction is consumed once and not re-presented.
- With FETCH_TIMEOUT_EN and the memory silent:
  - o_err rises TIMEOUT cycles after the request.
  - The request is re-issued to the same address.
  - o_err remains 1 after later normal fetches.
- Reset asserted mid-WAIT, with the response arriving during reset:
  - All outputs return to reset values.
  - The first request after release goes to RESET_PC.
